pong_match_ctrl: RTL

Match-level sequencer for the Pong game. It sits between the player controls and the ball datapath and decides when the ball moves, when it re-centres and which way it serves. It owns the score registers and the countdown match timer, and declares the winner. The ball datapath reports edge exits as goal pulses and advances only while `ball_run` is high.

---
 rtl/pong_pkg.sv | 34 +++
 rtl/sec_tick_gen.sv | 31 +++
 rtl/pong_match_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/pong_pkg.sv
// Shared types and helpers for the Pong match sequencer: state encoding,
// winner codes, score/seconds widths and a saturating score increment.
package pong_pkg;

   localparam int SCORE_W   = 4;
   localparam int SECONDS_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_POINT = 3'd3,
      ST_OVER  = 3'd4
   } match_state_t;

   localparam logic [1:0] WIN_NONE = 2'b00;
   localparam logic [1:0] WIN_P1   = 2'b01;
   localparam logic [1:0] WIN_P2   = 2'b10;
   localparam logic [1:0] WIN_DRAW = 2'b11;

   function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
      return (s == '1) ? s : s + 1'b1;
   endfunction

   // Equal scores are a draw only when the match can end on time.
   function automatic logic [1:0] winner_of(input logic [SCORE_W-1:0] s1,
                                            input logic [SCORE_W-1:0] s2,
                                            input logic draw_allowed);
      if (s1 > s2) return WIN_P1;
      if (s2 > s1) return WIN_P2;
      return draw_allowed ? WIN_DRAW : WIN_NONE;
   endfunction

endpackage

// File: rtl/sec_tick_gen.sv
// Enabled one-second prescaler: counts 0..TICKS_PER_SEC-1 while enabled,
// pulses sec_tick on the terminal count, and holds at 0 when disabled.
module sec_tick_gen #(
   parameter int TICKS_PER_SEC = 100_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic sec_tick
);

   localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (!enable) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

   assign sec_tick = enable && (count == LAST);

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/point flow, scores, match timer and winner.
// Define PONG_MATCH_TIMER_EN to build in the countdown match timer.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int TICKS_PER_SEC = 100_000_000,
   parameter int MATCH_SECONDS = 59,
   parameter int WIN_SCORE     = 7,
   parameter int SERVE_FRAMES  = 60
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       refresh_tick,
   input  logic       start_btn,
   input  logic       goal_left,
   input  logic       goal_right,
   output logic       ball_run,
   output logic       ball_recenter,
   output logic       serve_dir,
   output logic [3:0] score_player1,
   output logic [3:0] score_player2,
   output logic [5:0] seconds,
   output logic [2:0] state,
   output logic       game_over,
   output logic [1:0] winner
);

   localparam int FRAME_W = (SERVE_FRAMES > 0) ? $clog2(SERVE_FRAMES + 1) : 1;
   localparam logic [FRAME_W-1:0] FRAMES_LOAD = FRAME_W'(SERVE_FRAMES);
   localparam logic [SCORE_W-1:0] WIN_LIM = SCORE_W'(WIN_SCORE);

`ifdef PONG_MATCH_TIMER_EN
   localparam logic DRAW_OK = 1'b1;
`else
   localparam logic DRAW_OK = 1'b0;
`endif

   match_state_t       state_q, state_d;
   logic [SCORE_W-1:0] score1_q, score1_d;
   logic [SCORE_W-1:0] score2_q, score2_d;
   logic               serve_q, serve_d;
   logic [1:0]         winner_q, winner_d;
   logic [FRAME_W-1:0] frames_q, frames_d;
   logic               recenter_q, recenter_d;
   logic               run_q, run_d;
   logic               over_q, over_d;
   logic               expire;
   logic               timer_done;

`ifdef PONG_MATCH_TIMER_EN
   logic [SECONDS_W-1:0] seconds_q, seconds_d;
   logic                 sec_enable;
   logic                 sec_tick;

   assign sec_enable = (state_q == ST_SERVE) || (state_q == ST_PLAY);

   sec_tick_gen #(
      .TICKS_PER_SEC(TICKS_PER_SEC)
   ) u_sec_tick (
      .clk      (clk),
      .reset    (reset),
      .enable   (sec_enable),
      .sec_tick (sec_tick)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         seconds_q <= SECONDS_W'(MATCH_SECONDS);
      end else begin
         seconds_q <= seconds_d;
      end
   end

   assign seconds = seconds_q;
`else
   assign seconds = '0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         score1_q   <= '0;
         score2_q   <= '0;
         serve_q    <= 1'b0;
         winner_q   <= WIN_NONE;
         frames_q   <= '0;
         recenter_q <= 1'b0;
         run_q      <= 1'b0;
         over_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         score1_q   <= score1_d;
         score2_q   <= score2_d;
         serve_q    <= serve_d;
         winner_q   <= winner_d;
         frames_q   <= frames_d;
         recenter_q <= recenter_d;
         run_q      <= run_d;
         over_q     <= over_d;
      end
   end

   // Timer expiry is resolved first so the state case can let a goal score
   // in the same cycle and still override the destination with OVER.
   always_comb begin
      state_d    = state_q;
      score1_d   = score1_q;
      score2_d   = score2_q;
      serve_d    = serve_q;
      winner_d   = winner_q;
      frames_d   = frames_q;
      recenter_d = 1'b0;
      expire     = 1'b0;
      timer_done = 1'b0;
`ifdef PONG_MATCH_TIMER_EN
      seconds_d  = seconds_q;
      if (sec_tick) begin
         if (seconds_q <= SECONDS_W'(1)) begin
            seconds_d = '0;
            expire    = 1'b1;
         end else begin
            seconds_d = seconds_q - 1'b1;
         end
      end
      timer_done = (seconds_q == '0);
`endif

      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (start_btn) begin
               score1_d   = '0;
               score2_d   = '0;
               winner_d   = WIN_NONE;
               serve_d    = 1'b0;
`ifdef PONG_MATCH_TIMER_EN
               seconds_d  = SECONDS_W'(MATCH_SECONDS);
`endif
               recenter_d = 1'b1;
               frames_d   = FRAMES_LOAD;
               state_d    = ST_SERVE;
            end
         end
         ST_SERVE: begin
            if (refresh_tick) begin
               if (frames_q <= FRAME_W'(1)) begin
                  frames_d = '0;
                  state_d  = ST_PLAY;
               end else begin
                  frames_d = frames_q - 1'b1;
               end
            end
            if (expire) begin
               state_d = ST_OVER;
            end
         end
         ST_PLAY: begin
            if (goal_left) begin
               score2_d = sat_inc(score2_q);
            end
            if (goal_right) begin
               score1_d = sat_inc(score1_q);
            end
            if (goal_left && !goal_right) begin
               serve_d = 1'b0;
            end
            if (goal_right && !goal_left) begin
               serve_d = 1'b1;
            end
            if (goal_left || goal_right) begin
               state_d = ST_POINT;
            end
            if (expire) begin
               state_d = ST_OVER;
            end
         end
         ST_POINT: begin
            if ((score1_q >= WIN_LIM) || (score2_q >= WIN_LIM) || timer_done) begin
               state_d = ST_OVER;
            end else begin
               recenter_d = 1'b1;
               frames_d   = FRAMES_LOAD;
               state_d    = ST_SERVE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if ((state_d == ST_OVER) && (state_q != ST_OVER)) begin
         winner_d = winner_of(score1_d, score2_d, DRAW_OK);
      end

      run_d  = (state_d == ST_PLAY);
      over_d = (state_d == ST_OVER);
   end

   assign state         = state_q;
   assign score_player1 = score1_q;
   assign score_player2 = score2_q;
   assign serve_dir     = serve_q;
   assign winner        = winner_q;
   assign ball_recenter = recenter_q;
   assign ball_run      = run_q;
   assign game_over     = over_q;

endmodule
